// File: rtl/euler_pkg.sv
// rtl/euler_pkg.sv - shared state encoding, width defaults and reset constants for the Euler step controller
package euler_pkg;

    localparam int DATA_SIZE_DEF = 16;
    localparam int STEP_W_DEF    = 16;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LAUNCH   = 3'd1;
    localparam logic [2:0] ST_WAIT_CLR = 3'd2;
    localparam logic [2:0] ST_WAIT_FIN = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    localparam logic [2:0] ST_RESET    = ST_IDLE;

endpackage

// File: rtl/euler_step_counter.sv
// rtl/euler_step_counter.sv - completed-iteration up-counter with clear and terminal compare
module euler_step_counter #(
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [STEP_W-1:0] limit,
    output logic [STEP_W-1:0] count,
    output logic              last
);

    localparam logic [STEP_W-1:0] ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    // Compare one bit wider so an all-ones limit cannot alias through a wrap.
    assign last = ({1'b0, count} + {1'b0, ONE}) == {1'b0, limit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/euler_step_controller.sv
// rtl/euler_step_controller.sv - sequences N Euler core iterations; EULER_TIME_ACC_EN adds t_now/t_ovf time accumulator
module euler_step_controller
    import euler_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int STEP_W    = STEP_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic [STEP_W-1:0]    num_steps,
    input  logic [DATA_SIZE-1:0] h_in,
    input  logic [DATA_SIZE-1:0] t0,
    input  logic                 euler_finish,
    output logic                 euler_start,
    output logic [DATA_SIZE-1:0] h_step,
    output logic [STEP_W-1:0]    step_count,
    output logic                 busy,
    output logic                 done
`ifdef EULER_TIME_ACC_EN
    ,
    output logic [DATA_SIZE-1:0] t_now,
    output logic                 t_ovf
`endif
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [STEP_W-1:0] steps_lat;
    logic              accept;
    logic              step_inc;
    logic              last_step;

    assign accept   = (state == ST_IDLE) && go;
    // abort wins over a finish arriving in the same cycle, so no count is taken.
    assign step_inc = (state == ST_WAIT_FIN) && euler_finish && !abort;

    assign euler_start = (state == ST_LAUNCH);
    assign done        = (state == ST_FINISH);
    assign busy        = (state != ST_IDLE);

    euler_step_counter #(
        .STEP_W (STEP_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .inc   (step_inc),
        .limit (steps_lat),
        .count (step_count),
        .last  (last_step)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (go) state_nxt = (num_steps == '0) ? ST_FINISH : ST_LAUNCH;
            ST_LAUNCH:   state_nxt = ST_WAIT_CLR;
            ST_WAIT_CLR: if (!euler_finish) state_nxt = ST_WAIT_FIN;
            ST_WAIT_FIN: if (euler_finish) state_nxt = last_step ? ST_FINISH : ST_LAUNCH;
            ST_FINISH:   state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            steps_lat <= '0;
            h_step    <= '0;
        end else if (accept) begin
            steps_lat <= num_steps;
            h_step    <= h_in;
        end
    end

`ifdef EULER_TIME_ACC_EN
    localparam int MSB = DATA_SIZE - 1;

    logic [DATA_SIZE-1:0] t_sum;
    logic                 t_add_ovf;

    assign t_sum     = t_now + h_step;
    assign t_add_ovf = (t_now[MSB] == h_step[MSB]) && (t_sum[MSB] != t_now[MSB]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_now <= '0;
            t_ovf <= 1'b0;
        end else if (accept) begin
            t_now <= t0;
            t_ovf <= 1'b0;
        end else if (step_inc) begin
            t_now <= t_sum;
            t_ovf <= t_ovf | t_add_ovf;
        end
    end
`else
    logic unused_t0;
    assign unused_t0 = ^t0;
`endif

endmodule

// File: tb/tb_euler_step_controller.sv
// tb/tb_euler_step_controller.sv - scoreboard bench for euler_step_controller
module tb_euler_step_controller;

    localparam int DW = 16;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic          abort;
    logic [SW-1:0] num_steps;
    logic [DW-1:0] h_in;
    logic [DW-1:0] t0;
    logic          euler_finish;
    logic          euler_start;
    logic [DW-1:0] h_step;
    logic [SW-1:0] step_count;
    logic          busy;
    logic          done;
`ifdef EULER_TIME_ACC_EN
    logic [DW-1:0] t_now;
    logic          t_ovf;
`endif

    always #5 clk = ~clk;

    euler_step_controller #(
        .DATA_SIZE (DW),
        .STEP_W    (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .abort        (abort),
        .num_steps    (num_steps),
        .h_in         (h_in),
        .t0           (t0),
        .euler_finish (euler_finish),
        .euler_start  (euler_start),
        .h_step       (h_step),
        .step_count   (step_count),
        .busy         (busy),
        .done         (done)
`ifdef EULER_TIME_ACC_EN
        ,
        .t_now        (t_now),
        .t_ovf        (t_ovf)
`endif
    );

    typedef struct {
        bit            is_done;
        logic [DW-1:0] h;
        logic [SW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_run(input int n_starts, input logic [DW-1:0] h,
                            input bit with_done, input logic [SW-1:0] cnt);
        exp_t e;
        for (int i = 0; i < n_starts; i++) begin
            e.is_done = 1'b0; e.h = h; e.cnt = '0;
            exp_q.push_back(e);
        end
        if (with_done) begin
            e.is_done = 1'b1; e.h = h; e.cnt = cnt;
            exp_q.push_back(e);
        end
    endtask

    task automatic issue_go(input logic [SW-1:0] n, input logic [DW-1:0] h, input logic [DW-1:0] t);
        num_steps = n; h_in = h; t0 = t; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_count(input string name, input logic [SW-1:0] target, input int budget);
        int k = 0;
        while (step_count !== target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, {16'b0, step_count}, {16'b0, target});
    endtask

    // Euler core model: drops finish when it sees start, raises it 5 edges later and holds it.
    initial begin
        euler_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (euler_start === 1'b1) begin
                euler_finish = 1'b0;
                repeat (5) @(posedge clk);
                #1 euler_finish = 1'b1;
            end
        end
    end

    // Scoreboard monitor: every start/done pulse must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && (euler_start === 1'b1 || done === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: start=%b done=%b cnt=%h, nothing expected",
                         euler_start, done, step_count);
            end else begin
                e = exp_q.pop_front();
                if (e.is_done) begin
                    if (done !== 1'b1 || euler_start !== 1'b0 || step_count !== e.cnt) begin
                        failures++;
                        $display("FAIL sb_done: got done=%b start=%b cnt=%h expected done=1 cnt=%h",
                                 done, euler_start, step_count, e.cnt);
                    end
                end else begin
                    if (euler_start !== 1'b1 || done !== 1'b0 || h_step !== e.h) begin
                        failures++;
                        $display("FAIL sb_start: got start=%b done=%b h=%h expected start=1 h=%h",
                                 euler_start, done, h_step, e.h);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b0; go = 1'b0; abort = 1'b0;
        num_steps = '0; h_in = '0; t0 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {31'b0, busy}, 32'd0);
        check("rst_done",  {31'b0, done}, 32'd0);
        check("rst_start", {31'b0, euler_start}, 32'd0);
        check("rst_count", {16'b0, step_count}, 32'd0);
        check("rst_h",     {16'b0, h_step}, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Three iterations, core finishes 5 cycles after each start
        push_run(3, 16'h0100, 1'b1, 16'd3);
        issue_go(16'd3, 16'h0100, 16'h0000);
        check("go_start_latency", {31'b0, euler_start}, 32'd1);
        k = 0;
        while (euler_finish !== 1'b1 && k < 50) begin
            @(posedge clk); #2;
            k++;
        end
        check("finish_seen", {31'b0, euler_finish}, 32'd1);
        @(posedge clk); #1;
        check("finish_start_latency", {31'b0, euler_start}, 32'd1);
        wait_idle("run3_idle", 200);
        check("run3_count", {16'b0, step_count}, 32'd3);
        check("run3_h_hold", {16'b0, h_step}, 32'h0100);
        repeat (8) @(posedge clk);
        #1;

        // Zero iterations: straight to FINISH
        push_run(0, 16'h0200, 1'b1, 16'd0);
        issue_go(16'd0, 16'h0200, 16'h0000);
        check("zero_done", {31'b0, done}, 32'd1);
        check("zero_no_start", {31'b0, euler_start}, 32'd0);
        @(posedge clk); #1;
        check("zero_idle", {31'b0, busy}, 32'd0);
        check("zero_count", {16'b0, step_count}, 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Abort in WAIT_FIN after the first of four steps
        push_run(2, 16'h0300, 1'b0, 16'd0);
        issue_go(16'd4, 16'h0300, 16'h0000);
        wait_count("abort_step1", 16'd1, 50);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", {31'b0, busy}, 32'd0);
        check("abort_count", {16'b0, step_count}, 32'd1);
        check("abort_no_done", {31'b0, done}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_count_hold", {16'b0, step_count}, 32'd1);

        // go while busy must be ignored
        push_run(2, 16'h0100, 1'b1, 16'd2);
        issue_go(16'd2, 16'h0100, 16'h0000);
        @(posedge clk); #1;
        num_steps = 16'd7; h_in = 16'h0555; go = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        go = 1'b0;
        check("busy_go_h", {16'b0, h_step}, 32'h0100);
        wait_idle("busy_go_idle", 200);
        check("busy_go_count", {16'b0, step_count}, 32'd2);
        repeat (8) @(posedge clk);
        #1;

        // Reset during WAIT_CLR, then a clean run
        push_run(1, 16'h0400, 1'b0, 16'd0);
        issue_go(16'd3, 16'h0400, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mrst_busy",  {31'b0, busy}, 32'd0);
        check("mrst_start", {31'b0, euler_start}, 32'd0);
        check("mrst_done",  {31'b0, done}, 32'd0);
        check("mrst_count", {16'b0, step_count}, 32'd0);
        check("mrst_h",     {16'b0, h_step}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("mrst_stays_idle", {31'b0, busy}, 32'd0);
        push_run(2, 16'h0600, 1'b1, 16'd2);
        issue_go(16'd2, 16'h0600, 16'h0000);
        wait_idle("mrst_rerun_idle", 200);
        check("mrst_rerun_count", {16'b0, step_count}, 32'd2);
        repeat (8) @(posedge clk);
        #1;

`ifdef EULER_TIME_ACC_EN
        push_run(2, 16'h0100, 1'b1, 16'd2);
        issue_go(16'd2, 16'h0100, 16'h7F00);
        check("tacc_load", {16'b0, t_now}, 32'h7F00);
        check("tacc_ovf_clr", {31'b0, t_ovf}, 32'd0);
        wait_idle("tacc_idle", 200);
        check("tacc_t_now", {16'b0, t_now}, 32'h8100);
        check("tacc_ovf", {31'b0, t_ovf}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        push_run(1, 16'h0001, 1'b1, 16'd1);
        issue_go(16'd1, 16'h0001, 16'h0000);
        wait_idle("tacc2_idle", 200);
        check("tacc2_t_now", {16'b0, t_now}, 32'h0001);
        check("tacc2_ovf", {31'b0, t_ovf}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
`endif

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
